// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_bytes_tx sender among N_REQ requesters,
// with an inter-frame gap after each done pulse and a watchdog on the done wait.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int BYTES       = 5,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [N_REQ-1:0]         req_vld,
    input  logic [N_REQ*BYTES*8-1:0] req_data,
    output logic [N_REQ-1:0]         req_ack,
    output logic                     tx_bytes_en,
    output logic [BYTES*8-1:0]       tx_bytes_data,
    input  logic                     tx_bytes_done,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_timeout
);
    localparam int IW = $clog2(N_REQ);
    localparam int FW = BYTES * 8;
    localparam int CMAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int CW = $clog2(CMAX + 2);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
    localparam logic [CW-1:0] WDT_LAST = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
    localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    win;
    logic [IW-1:0]    idx;
    logic             start;
    logic             timeout;
    logic [N_REQ-1:0] ack_nx;
    logic             busy_nx;
    logic             err_nx;

    // Scan from the far end back toward ptr+1 so the nearest requester after ptr overrides.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req_vld[idx]) win = idx;
        end
    end

    // A done arriving on the final watchdog clock wins over the abort.
    always_comb timeout = (TIMEOUT_CYC != 0) && (cnt == WDT_LAST) && !tx_bytes_done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            ptr           <= PTR_RST;
            grant_id      <= '0;
            tx_bytes_data <= '0;
            req_ack       <= '0;
            tx_bytes_en   <= 1'b0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            req_ack     <= ack_nx;
            tx_bytes_en <= start;
            busy        <= busy_nx;
            err_timeout <= err_nx;
            if (start) begin
                ptr           <= win;
                grant_id      <= win;
                tx_bytes_data <= req_data[win*FW +: FW];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req_vld ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (tx_bytes_done || timeout) ? ((GAP_CYC == 0) ? IDLE : GAP) : WAIT;
            GAP:     state_nx = (cnt == GAP_LAST) ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; the counter restarts on every state change.
    always_comb begin
        start   = (state == IDLE) && |req_vld;
        ack_nx  = start ? (N_REQ'(1) << win) : '0;
        busy_nx = state_nx != IDLE;
        err_nx  = (state == WAIT) && timeout;
        cnt_nx  = (state_nx == state && (state == WAIT || state == GAP)) ? cnt + 1'b1 : '0;
    end
endmodule
